uart_gen2: RTL

UART_GEN2 -- requirements
Module: uart_gen2

---
 rtl/uart_gen2_if.sv | 26 ++
 rtl/uart_gen2.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_gen2_if.sv
// Host-side FIFO bus of uart_gen2: TX write port and fall-through RX read port.
interface uart_gen2_if #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 4
);
  logic              tx_wen;
  logic [DATA_W-1:0] tx_wdata;
  logic              tx_full;
  logic              tx_empty;
  logic [FIFO_AW:0]  tx_usedw;
  logic              rx_ren;
  logic [DATA_W-1:0] rx_rdata;
  logic              rx_empty;
  logic              rx_full;
  logic [FIFO_AW:0]  rx_usedw;

  modport master (
    output tx_wen, tx_wdata, rx_ren,
    input  tx_full, tx_empty, tx_usedw, rx_rdata, rx_empty, rx_full, rx_usedw
  );

  modport slave (
    input  tx_wen, tx_wdata, rx_ren,
    output tx_full, tx_empty, tx_usedw, rx_rdata, rx_empty, rx_full, rx_usedw
  );
endinterface

// File: rtl/uart_gen2.sv
// UART with programmable baud tick, OSR-oversampled TX/RX and 2^FIFO_AW deep FIFOs.
// Optional parity bit enabled by defining UART_GEN2_PARITY_EN.
module uart_gen2_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   usedw
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          push_ok, pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign usedw   = cnt;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = empty ? '0 : mem[rp];

  always_ff @(posedge clk)
    if (!rst && push_ok) mem[wp] <= din;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module uart_gen2 #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 4,
  parameter int OSR     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        latch_baud,
  input  logic [15:0] baud_word,
  input  logic        stop2,
  input  logic        self_loop,
  input  logic        rxd,
  output logic        txd,
  output logic        tx_work,
  output logic        rx_overflow,
  output logic        rx_frame_err,
  input  logic        err_clr,
  uart_gen2_if.slave  bus
`ifdef UART_GEN2_PARITY_EN
  ,
  input  logic        parity_odd,
  output logic        rx_parity_err
`endif
);
  localparam int TW = $clog2(2*OSR);
  localparam int BW = $clog2(DATA_W);
  localparam logic [TW-1:0] BIT_END  = TW'(OSR-1);
  localparam logic [TW-1:0] STOP2_END = TW'(2*OSR-1);
  localparam logic [TW-1:0] HALF_END = TW'(OSR/2-1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W-1);

`ifdef UART_GEN2_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // ---- baud tick ----
  logic [15:0] div, bcnt;
  logic        tick;

  assign tick = (bcnt == div) && !latch_baud;

  always_ff @(posedge clk) begin
    if (rst) begin
      div  <= '0;
      bcnt <= '0;
    end else if (latch_baud) begin
      div  <= baud_word;
      bcnt <= '0;
    end else if (tick) begin
      bcnt <= '0;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  // ---- TX ----
  state_t            tx_st;
  logic [TW-1:0]     tx_tc;
  logic [BW-1:0]     tx_bc;
  logic [DATA_W-1:0] tx_sh, tx_head;
  logic              tx_pop, tx_bit_end, tx_stop_end;
`ifdef UART_GEN2_PARITY_EN
  logic              tx_pb;
`endif

  assign tx_bit_end  = (tx_tc == BIT_END);
  assign tx_stop_end = (tx_tc == (stop2 ? STOP2_END : BIT_END));
  // Pop on the tick that starts a frame, including the back-to-back restart out of STOP.
  assign tx_pop = tick && !bus.tx_empty &&
                  ((tx_st == S_IDLE) || (tx_st == S_STOP && tx_stop_end));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st   <= S_IDLE;
      txd     <= 1'b1;
      tx_work <= 1'b0;
      tx_tc   <= '0;
      tx_bc   <= '0;
      tx_sh   <= '0;
`ifdef UART_GEN2_PARITY_EN
      tx_pb   <= 1'b0;
`endif
    end else if (tick) begin
      case (tx_st)
        S_IDLE: if (tx_pop) begin
          tx_st   <= S_START;
          txd     <= 1'b0;
          tx_work <= 1'b1;
          tx_sh   <= tx_head;
          tx_tc   <= '0;
`ifdef UART_GEN2_PARITY_EN
          tx_pb   <= ^tx_head ^ parity_odd;
`endif
        end
        S_START: if (tx_bit_end) begin
          tx_st <= S_DATA;
          tx_tc <= '0;
          tx_bc <= '0;
          txd   <= tx_sh[0];
        end else tx_tc <= tx_tc + 1'b1;
        S_DATA: if (tx_bit_end) begin
          tx_tc <= '0;
          if (tx_bc == LAST_BIT) begin
`ifdef UART_GEN2_PARITY_EN
            tx_st <= S_PARITY;
            txd   <= tx_pb;
`else
            tx_st <= S_STOP;
            txd   <= 1'b1;
`endif
          end else begin
            tx_bc <= tx_bc + 1'b1;
            tx_sh <= tx_sh >> 1;
            txd   <= tx_sh[1];
          end
        end else tx_tc <= tx_tc + 1'b1;
`ifdef UART_GEN2_PARITY_EN
        S_PARITY: if (tx_bit_end) begin
          tx_st <= S_STOP;
          tx_tc <= '0;
          txd   <= 1'b1;
        end else tx_tc <= tx_tc + 1'b1;
`endif
        S_STOP: if (tx_stop_end) begin
          tx_tc <= '0;
          if (tx_pop) begin
            tx_st <= S_START;
            txd   <= 1'b0;
            tx_sh <= tx_head;
`ifdef UART_GEN2_PARITY_EN
            tx_pb <= ^tx_head ^ parity_odd;
`endif
          end else begin
            tx_st   <= S_IDLE;
            tx_work <= 1'b0;
          end
        end else tx_tc <= tx_tc + 1'b1;
        default: tx_st <= S_IDLE;
      endcase
    end
  end

  uart_gen2_fifo #(.W(DATA_W), .AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.tx_wen),
    .pop   (tx_pop),
    .din   (bus.tx_wdata),
    .dout  (tx_head),
    .empty (bus.tx_empty),
    .full  (bus.tx_full),
    .usedw (bus.tx_usedw)
  );

  // ---- RX ----
  // sync[1] is the synchronised line, sync[2] its previous value for edge detect.
  logic [2:0]        sync;
  logic              rs, rs_prev;
  state_t            rx_st;
  logic [TW-1:0]     rx_tc;
  logic [BW-1:0]     rx_bc;
  logic [DATA_W-1:0] rx_sh;
  logic              rx_bit_end, stop_smp, par_ok, rx_push;
  logic              fe_set, ov_set;

  assign rs      = sync[1];
  assign rs_prev = sync[2];

  always_ff @(posedge clk) begin
    if (rst) sync <= 3'b111;
    else     sync <= {sync[1:0], self_loop ? txd : rxd};
  end

  assign rx_bit_end = (rx_tc == BIT_END);
  assign stop_smp   = tick && (rx_st == S_STOP) && rx_bit_end;
`ifdef UART_GEN2_PARITY_EN
  logic rx_pb, pe_set;
  assign par_ok = ((^rx_sh ^ rx_pb) == parity_odd);
  assign pe_set = stop_smp && rs && !par_ok;
`else
  assign par_ok = 1'b1;
`endif
  assign fe_set  = stop_smp && !rs;
  assign ov_set  = stop_smp && rs && par_ok && bus.rx_full;
  assign rx_push = stop_smp && rs && par_ok && !bus.rx_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st <= S_IDLE;
      rx_tc <= '0;
      rx_bc <= '0;
      rx_sh <= '0;
`ifdef UART_GEN2_PARITY_EN
      rx_pb <= 1'b0;
`endif
    end else begin
      case (rx_st)
        S_IDLE: if (rs_prev && !rs) begin
          rx_st <= S_START;
          rx_tc <= '0;
        end
        S_START: if (tick) begin
          if (rx_tc == HALF_END) begin
            rx_tc <= '0;
            rx_bc <= '0;
            rx_st <= rs ? S_IDLE : S_DATA;
          end else rx_tc <= rx_tc + 1'b1;
        end
        S_DATA: if (tick) begin
          if (rx_bit_end) begin
            rx_tc <= '0;
            rx_sh <= {rs, rx_sh[DATA_W-1:1]};
            if (rx_bc == LAST_BIT) begin
`ifdef UART_GEN2_PARITY_EN
              rx_st <= S_PARITY;
`else
              rx_st <= S_STOP;
`endif
            end else rx_bc <= rx_bc + 1'b1;
          end else rx_tc <= rx_tc + 1'b1;
        end
`ifdef UART_GEN2_PARITY_EN
        S_PARITY: if (tick) begin
          if (rx_bit_end) begin
            rx_tc <= '0;
            rx_pb <= rs;
            rx_st <= S_STOP;
          end else rx_tc <= rx_tc + 1'b1;
        end
`endif
        S_STOP: if (tick) begin
          if (rx_bit_end) begin
            rx_tc <= '0;
            rx_st <= S_IDLE;
          end else rx_tc <= rx_tc + 1'b1;
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

  // Sticky flags: a same-cycle set wins over err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overflow   <= 1'b0;
      rx_frame_err  <= 1'b0;
`ifdef UART_GEN2_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_overflow   <= ov_set | (rx_overflow  & ~err_clr);
      rx_frame_err  <= fe_set | (rx_frame_err & ~err_clr);
`ifdef UART_GEN2_PARITY_EN
      rx_parity_err <= pe_set | (rx_parity_err & ~err_clr);
`endif
    end
  end

  uart_gen2_fifo #(.W(DATA_W), .AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (bus.rx_ren),
    .din   (rx_sh),
    .dout  (bus.rx_rdata),
    .empty (bus.rx_empty),
    .full  (bus.rx_full),
    .usedw (bus.rx_usedw)
  );
endmodule
